// File: rtl/riscv_pkg.sv
// Shared RV32I fetch definitions: data width, reset PC, NOP encoding and the
// instruction-buffer entry carried from fetch to decode.
package riscv_pkg;

  localparam int unsigned RV_XLEN = 32;

  localparam logic [RV_XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0]        NOP_INSTR        = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]        instr;
    logic [RV_XLEN-1:0] pc;
    logic               misalign;
  } fetch_entry_t;

  function automatic logic [RV_XLEN-1:0] word_align(input logic [RV_XLEN-1:0] addr);
    return addr & ~(RV_XLEN'(3));
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of DEPTH entries of type T; head is a registered read, 0-cycle visibility after push edge.
// No internal backpressure: caller guarantees no push when full / no pop when empty; flush beats pop and may carry a push.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter type         T     = logic [31:0]
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  T                         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output T                         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  T               mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;

  assign head = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      // A flush may restart the queue with one fresh entry in slot 0.
      rd_ptr <= '0;
      if (push) begin
        mem[0] <= push_data;
        wr_ptr <= AW'(1);
        count  <= (AW+1)'(1);
      end else begin
        wr_ptr <= '0;
        count  <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: PC, credit-limited imem requests, in-order response buffer to decode (mem latency + 1 to if_valid).
// Decode stalls via if_ready; redirects flush and drop stale responses. FETCH_MISALIGN_TRAP_EN traps misaligned targets.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN       = RV_XLEN,
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic            if_misalign
);

  localparam int unsigned CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] CREDITS = (CW+1)'(FIFO_DEPTH);

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam logic MISALIGN_EN = 1'b1;
`else
  localparam logic MISALIGN_EN = 1'b0;
`endif

  logic [XLEN-1:0] pc;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   fifo_cnt;
  logic [CW-1:0]   pcq_cnt;
  logic [CW-1:0]   outstanding;
  logic [CW:0]     credit_used;
  logic            started;
  logic            halted;

  logic            pop;
  logic            req_fire;
  logic            rsp_keep;
  logic            rsp_drop;
  logic            mis_redirect;
  logic            fifo_push;
  fetch_entry_t    push_entry;
  fetch_entry_t    head_entry;
  logic [XLEN-1:0] pcq_head;

  // Every in-flight request is either still owed a PC-queue slot or is a stale one awaiting drop.
  assign outstanding = pcq_cnt + drop_cnt;

  assign pop         = if_valid && if_ready;
  // A pop this cycle frees its slot before any new response can land, keeping 1 instr/cycle.
  assign credit_used = {1'b0, outstanding} + {1'b0, fifo_cnt} - {{CW{1'b0}}, pop};

  assign imem_req_valid = started && !halted && !redirect_valid && (credit_used < CREDITS);
  assign imem_addr      = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_drop     = imem_rsp_valid && (drop_cnt != '0);
  assign rsp_keep     = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
  assign mis_redirect = MISALIGN_EN && redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign fifo_push    = rsp_keep || mis_redirect;

  always_comb begin
    push_entry = '0;
    if (mis_redirect) begin
      push_entry.instr    = NOP_INSTR;
      push_entry.pc       = redirect_pc;
      push_entry.misalign = 1'b1;
    end else begin
      push_entry.instr    = imem_rsp_data;
      push_entry.pc       = pcq_head;
      push_entry.misalign = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      drop_cnt <= '0;
      started  <= 1'b0;
      halted   <= 1'b0;
    end else begin
      started <= 1'b1;
      if (redirect_valid) begin
        // No request fires in a redirect cycle, so everything still in flight is stale.
        pc       <= word_align(redirect_pc);
        drop_cnt <= outstanding - CW'(imem_rsp_valid);
        halted   <= mis_redirect;
      end else begin
        if (req_fire) begin
          pc <= pc + XLEN'(4);
        end
        if (rsp_drop) begin
          drop_cnt <= drop_cnt - CW'(1);
        end
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (fetch_entry_t)
  ) u_ibuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head_entry),
    .count     (fifo_cnt)
  );

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (logic [XLEN-1:0])
  ) u_pcq (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (req_fire),
    .push_data (pc),
    .pop       (rsp_keep),
    .flush     (redirect_valid),
    .head      (pcq_head),
    .count     (pcq_cnt)
  );

  assign if_valid    = (fifo_cnt != '0);
  assign if_instr    = head_entry.instr;
  assign if_pc       = head_entry.pc;
  assign if_misalign = head_entry.misalign & MISALIGN_EN;

endmodule
